// File: rtl/parking_occupancy_tracker.sv
// Parking occupancy tracker: synchronises and debounces per-spot sensors, counts
// occupied spots and offers a request/acknowledge snapshot of the count.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sensor_in      raw per-spot occupancy, asynchronous to clk
//   stable_map     debounced occupancy map
//   parked, free   registered occupied / vacant spot counts
//   full, empty    registered count flags
//   change_pulse   one-cycle strobe whenever parked takes a new value
//   count_valid    high once startup settling has completed
//   snap_req       level snapshot request
//   snap_ack       snapshot acknowledge, held while snap_req stays high
//   snap_count     count captured at the start of the handshake
module parking_occupancy_tracker #(
    parameter int unsigned N_SPOTS    = 8,
    parameter int unsigned DEB_CYCLES = 4,
    localparam int unsigned CNT_W     = $clog2(N_SPOTS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SPOTS-1:0] sensor_in,
    output logic [N_SPOTS-1:0] stable_map,
    output logic [CNT_W-1:0]   parked,
    output logic [CNT_W-1:0]   free,
    output logic               full,
    output logic               empty,
    output logic               change_pulse,
    output logic               count_valid,
    input  logic               snap_req,
    output logic               snap_ack,
    output logic [CNT_W-1:0]   snap_count
);

    // Debounce counter only needs to reach DEB_CYCLES-1 before the flip edge.
    localparam int unsigned DEB_W  = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    // Startup counter must reach DEB_CYCLES+2.
    localparam int unsigned INIT_W = $clog2(DEB_CYCLES + 3);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [N_SPOTS-1:0] sync1;
    logic [N_SPOTS-1:0] sync2;
    logic [DEB_W-1:0]   deb_cnt [N_SPOTS];
    logic [CNT_W-1:0]   pop_c;
    state_t             state;
    state_t             state_next;
    logic [INIT_W-1:0]  init_cnt;
    logic               capture_c;
    logic               count_valid_c;
    logic               snap_ack_c;

    // Two-flop synchroniser on every sensor bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: flip once the mismatch has been seen DEB_CYCLES edges in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_map <= '0;
            for (int i = 0; i < int'(N_SPOTS); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_SPOTS); i++) begin
                if (sync2[i] != stable_map[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        stable_map[i] <= sync2[i];
                        deb_cnt[i]    <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Population count of the debounced map; all simultaneous flips land together.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(N_SPOTS); i++) begin
            pop_c = pop_c + CNT_W'(stable_map[i]);
        end
    end

    // Registered count, derived flags and change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked       <= '0;
            free         <= CNT_W'(N_SPOTS);
            full         <= 1'b0;
            empty        <= 1'b1;
            change_pulse <= 1'b0;
        end else begin
            parked       <= pop_c;
            free         <= CNT_W'(N_SPOTS) - pop_c;
            full         <= (pop_c == CNT_W'(N_SPOTS));
            empty        <= (pop_c == '0);
            change_pulse <= (pop_c != parked);
        end
    end

    // Startup settling counter, advances only while in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT && init_cnt != INIT_W'(DEB_CYCLES + 2)) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_cnt == INIT_W'(DEB_CYCLES + 2)) state_next = ST_RUN;
            ST_RUN:  if (snap_req) state_next = ST_ACK;
            ST_ACK:  if (!snap_req) state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Output decode; values are registered below so they line up with the new state.
    always_comb begin
        capture_c     = 1'b0;
        count_valid_c = 1'b0;
        snap_ack_c    = 1'b0;
        capture_c     = (state == ST_RUN) && snap_req;
        count_valid_c = (state_next != ST_INIT);
        snap_ack_c    = (state_next == ST_ACK);
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_valid <= 1'b0;
            snap_ack    <= 1'b0;
            snap_count  <= '0;
        end else begin
            count_valid <= count_valid_c;
            snap_ack    <= snap_ack_c;
            if (capture_c) begin
                snap_count <= parked;
            end
        end
    end

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Bench for parking_occupancy_tracker (N_SPOTS = 8, DEB_CYCLES = 4): a behavioural
// model built from sample histories and a debounce window, compared every cycle,
// plus directed scenarios with literal expectations followed by random stimulus.
module tb_parking_occupancy_tracker;

    localparam int N   = 8;
    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sensor_in;
    logic [7:0] stable_map;
    logic [3:0] parked;
    logic [3:0] free;
    logic       full;
    logic       empty;
    logic       change_pulse;
    logic       count_valid;
    logic       snap_req;
    logic       snap_ack;
    logic [3:0] snap_count;

    int checks   = 0;
    int failures = 0;

    parking_occupancy_tracker #(.N_SPOTS(N), .DEB_CYCLES(DEB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_in    (sensor_in),
        .stable_map   (stable_map),
        .parked       (parked),
        .free         (free),
        .full         (full),
        .empty        (empty),
        .change_pulse (change_pulse),
        .count_valid  (count_valid),
        .snap_req     (snap_req),
        .snap_ack     (snap_ack),
        .snap_count   (snap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] sq[$];          // last two raw samples (synchroniser delay)
    logic [7:0] win[$];         // last DEB synchronised words
    logic [7:0] m_stable = '0;
    int         m_parked = 0;
    bit         m_change = 0;
    bit         m_valid  = 0;
    bit         m_ack    = 0;
    int         m_snap   = 0;
    int         m_since  = 0;

    initial begin
        sq.push_back(8'h00);
        sq.push_back(8'h00);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq.delete();
            sq.push_back(8'h00);
            sq.push_back(8'h00);
            win.delete();
            m_stable = '0;
            m_parked = 0;
            m_change = 0;
            m_valid  = 0;
            m_ack    = 0;
            m_snap   = 0;
            m_since  = 0;
        end else begin
            int         p_new;
            logic [7:0] synced;
            p_new    = $countones(m_stable);
            m_change = (p_new != m_parked);
            if (m_since >= DEB + 3) begin
                if (!m_ack && snap_req) begin
                    m_snap = m_parked;
                    m_ack  = 1;
                end else if (m_ack && !snap_req) begin
                    m_ack = 0;
                end
            end
            m_parked = p_new;
            if (m_since < 1000) m_since++;
            m_valid = (m_since >= DEB + 3);
            // Value seen by the debouncer is the raw sample from two edges earlier.
            synced = sq[0];
            sq.push_back(sensor_in);
            void'(sq.pop_front());
            win.push_back(synced);
            if (win.size() > DEB) void'(win.pop_front());
            if (win.size() == DEB) begin
                for (int b = 0; b < N; b++) begin
                    bit all_diff;
                    all_diff = 1;
                    foreach (win[j]) if (win[j][b] == m_stable[b]) all_diff = 0;
                    if (all_diff) m_stable[b] = ~m_stable[b];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("stable_map",   int'(stable_map),   int'(m_stable));
        check("parked",       int'(parked),       m_parked);
        check("free",         int'(free),         N - m_parked);
        check("full",         int'(full),         int'(m_parked == N));
        check("empty",        int'(empty),        int'(m_parked == 0));
        check("change_pulse", int'(change_pulse), int'(m_change));
        check("count_valid",  int'(count_valid),  int'(m_valid));
        check("snap_ack",     int'(snap_ack),     int'(m_ack));
        check("snap_count",   int'(snap_count),   m_snap);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        rst_n     = 1'b0;
        sensor_in = 8'h00;
        snap_req  = 1'b0;
        tick(2);
        check("rst_parked", int'(parked), 0);
        check("rst_free", int'(free), 8);
        check("rst_empty", int'(empty), 1);
        check("rst_valid", int'(count_valid), 0);

        // count_valid rises on the 7th edge after release
        rst_n = 1'b1;
        tick(6);
        check("valid_e6", int'(count_valid), 0);
        tick(1);
        check("valid_e7", int'(count_valid), 1);

        // 0x00 -> 0x0F: stable at edge +6, count one edge later
        sensor_in = 8'h0F;
        tick(5);
        check("map_e5", int'(stable_map), 8'h00);
        tick(1);
        check("map_e6", int'(stable_map), 8'h0F);
        tick(1);
        check("parked_4", int'(parked), 4);
        check("free_4", int'(free), 4);
        check("pulse_4", int'(change_pulse), 1);
        tick(1);
        check("pulse_off", int'(change_pulse), 0);

        // 3-cycle glitch on bit 7 is rejected
        pulses = 0;
        sensor_in = 8'h8F;
        for (int i = 0; i < 3; i++) begin tick(1); pulses += int'(change_pulse); end
        sensor_in = 8'h0F;
        for (int i = 0; i < 10; i++) begin tick(1); pulses += int'(change_pulse); end
        check("glitch_map", int'(stable_map), 8'h0F);
        check("glitch_parked", int'(parked), 4);
        check("glitch_pulses", pulses, 0);

        // full and back
        sensor_in = 8'hFF;
        tick(8);
        check("full_1", int'(full), 1);
        check("parked_8", int'(parked), 8);
        check("free_0", int'(free), 0);
        sensor_in = 8'hFE;
        tick(8);
        check("full_0", int'(full), 0);
        check("parked_7", int'(parked), 7);

        // net-zero swap
        sensor_in = 8'h01;
        tick(8);
        check("parked_1", int'(parked), 1);
        pulses = 0;
        sensor_in = 8'h02;
        for (int i = 0; i < 8; i++) begin tick(1); pulses += int'(change_pulse); end
        check("swap_pulses", pulses, 0);
        check("swap_map", int'(stable_map), 8'h02);
        check("swap_parked", int'(parked), 1);

        // snapshot handshake
        sensor_in = 8'h1F;
        tick(8);
        check("parked_5", int'(parked), 5);
        snap_req  = 1'b1;
        sensor_in = 8'h3F;
        tick(1);
        check("ack_up", int'(snap_ack), 1);
        check("snap_5", int'(snap_count), 5);
        tick(9);
        check("ack_held", int'(snap_ack), 1);
        check("snap_frozen", int'(snap_count), 5);
        check("parked_6", int'(parked), 6);
        snap_req = 1'b0;
        tick(1);
        check("ack_down", int'(snap_ack), 0);
        check("snap_kept", int'(snap_count), 5);
        snap_req = 1'b1;
        tick(1);
        check("ack_again", int'(snap_ack), 1);
        check("snap_6", int'(snap_count), 6);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack", int'(snap_ack), 0);
        check("rst_snap", int'(snap_count), 0);
        check("rst_valid_mid", int'(count_valid), 0);
        check("rst_parked_mid", int'(parked), 0);
        snap_req = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6) sensor_in = 8'($urandom);
            else if (r < 14) begin
                int idx;
                idx = int'($urandom_range(0, 7));
                sensor_in[idx] = ~sensor_in[idx];
            end
            if ($urandom_range(0, 15) == 0) snap_req = ~snap_req;
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick(1);
        end

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_tracker.md
PARKING_OCCUPANCY_TRACKER -- requirements
Module: parking_occupancy_tracker

Interface
REQ-001 Parameter N_SPOTS, default 8: number of spot sensors; SHALL be legal for 1..64.
REQ-002 Parameter DEB_CYCLES, default 4: debounce length in clock cycles; SHALL be legal for 1..255.
REQ-003 Derived width CNT_W = ceil(log2(N_SPOTS+1)); SHALL NOT be a user override.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 sensor_in  in  N_SPOTS  raw per-spot occupancy (1 = car present); asynchronous to clk.
REQ-008 stable_map  out  N_SPOTS  debounced occupancy map.
REQ-009 parked  out  CNT_W  registered count of ones in stable_map.
REQ-010 free  out  CNT_W  registered N_SPOTS - parked.
REQ-011 full  out  1  registered, high when parked == N_SPOTS.
REQ-012 empty  out  1  registered, high when parked == 0.
REQ-013 change_pulse  out  1  one-cycle strobe on any change of parked.
REQ-014 count_valid  out  1  high once startup settling completes.
REQ-015 snap_req  in  1  level request for a count snapshot.
REQ-016 snap_ack  out  1  snapshot handshake acknowledge.
REQ-017 snap_count  out  CNT_W  captured count, held while snap_ack high and after.

Function
REQ-018 Each sensor_in bit SHALL pass a 2-flop synchroniser before any other use.
REQ-019 Per bit, a debounce counter SHALL increment while the synced bit differs from stable_map, and clear when equal.
REQ-020 A stable_map bit SHALL flip on the edge where its mismatch has persisted DEB_CYCLES consecutive cycles; the counter clears on that edge.
REQ-021 Pulses shorter than DEB_CYCLES synced cycles SHALL leave stable_map unchanged.
REQ-022 Latency: a sensor_in step held steady SHALL reach stable_map DEB_CYCLES+2 edges later and parked/free/full/empty one edge after that.
REQ-023 Popcount SHALL be a combinational adder tree over stable_map, registered once; simultaneous flips of any number of bits SHALL be counted in the same cycle, no lost or double counts.
REQ-024 parked SHALL never exceed N_SPOTS; free + parked == N_SPOTS in every cycle.
REQ-025 change_pulse SHALL be high exactly in the cycle after parked takes a new value; net-zero simultaneous flips (one in, one out) SHALL NOT pulse.
REQ-026 Control FSM states: INIT, RUN, ACK.
REQ-027 INIT: startup counter runs DEB_CYCLES+3 cycles after reset release, then -> RUN; count_valid = 0 in INIT, 1 in RUN and ACK.
REQ-028 snap_req SHALL be ignored in INIT.
REQ-029 RUN with snap_req = 1: capture current parked into snap_count, -> ACK; snap_ack high from the next cycle.
REQ-030 ACK: snap_ack held high, snap_count frozen, while snap_req = 1; snap_req = 0 -> RUN with snap_ack low next cycle.
REQ-031 New capture SHALL require snap_req low for at least one cycle (one snapshot per request).
REQ-032 Debounce and counting SHALL continue in all FSM states.

Reset
REQ-033 rst_n low SHALL immediately clear: synchronisers, debounce counters, stable_map = 0, parked = 0, free = N_SPOTS, empty = 1, full = 0, change_pulse = 0, count_valid = 0, snap_ack = 0, snap_count = 0, FSM = INIT.
REQ-034 Reset asserted mid-debounce or mid-handshake SHALL discard in-flight state; no pulse or ack on release.
REQ-035 After release, sensors already high SHALL be counted via normal debounce (no reset-time shortcut).

Verification (N_SPOTS = 8, DEB_CYCLES = 4)
REQ-036 Reset, sensor_in = 8'h00 -> parked 0, free 8, empty 1, count_valid rises 7 edges after release.
REQ-037 sensor_in 8'h00 -> 8'h0F held -> stable_map 8'h0F at edge +6, parked 4, free 4, one change_pulse.
REQ-038 3-cycle glitch on bit 7 -> stable_map, parked, change_pulse unchanged.
REQ-039 sensor_in 8'h0F -> 8'hFF -> full 1, parked 8, free 0; then 8'hFF -> 8'hFE -> full 0, parked 7.
REQ-040 8'h01 -> 8'h02 same edge -> parked stays 1, no change_pulse, stable_map 8'h02.
REQ-041 snap_req high with parked 5, held 10 cycles while count moves to 6 -> snap_ack next edge, snap_count stays 5; snap_req low -> snap_ack low next edge; rst_n pulse during ACK -> snap_ack 0 immediately.
